// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: MEM-stage load/store unit to a single-outstanding word memory.
// Takes one RV32I load/store from the pipeline and issues one word-wide memory
// request with byte enables and lane-replicated store data. Load data is
// extended into o_lsu_rdata. o_lsu_ready pulses for exactly one cycle when the
// access finishes, whether it completes, faults or times out.
//
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   - a misaligned half or word access faults and no memory request is made.
//   undefined - the offending low address bits are forced to zero and the access is performed.
//
// Parameters:
//   TIMEOUT_CYC   REQ cycles without i_mem_ack before the access is abandoned (1..1023)
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_lsu_valid           access request, held by the pipeline until o_lsu_ready
//   i_lsu_wren            1 = store, 0 = load
//   i_lsu_addr            byte address
//   i_lsu_wdata           store data, right-justified
//   i_lsu_funct3          RV32I load/store funct3
//   o_lsu_ready           one-cycle completion pulse
//   o_lsu_rdata           extended load result (0 for stores and faults)
//   o_lsu_err             access fault, valid with o_lsu_ready
//   o_mem_req, o_mem_we   memory request and write strobe
//   o_mem_addr            word address
//   o_mem_be, o_mem_wdata byte enables and replicated store data
//   i_mem_ack             memory completion
//   i_mem_rdata           word read data, valid with i_mem_ack
module lsu_mem_resp #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_wren,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [2:0]  i_lsu_funct3,
  output logic        o_lsu_ready,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [29:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic             wren_q, wren_d;

  logic        ready_d, err_d, req_d, we_d;
  logic [31:0] rdata_d, wdata_d;
  logic [29:0] addr_d;
  logic [3:0]  be_d;

  logic        req_fault;
  logic [1:0]  eff_off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        timeout;

  // Extend the addressed lane of a read word according to the load funct3.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
    logic [31:0] lane;
    lane = w >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // Decode of the incoming request: legality, effective lane offset, enables, data.
  always_comb begin
    logic legal;
    legal = i_lsu_wren ? (i_lsu_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (i_lsu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
    begin
      logic misaligned;
      misaligned = ((i_lsu_funct3[1:0] == 2'b01) && i_lsu_addr[0]) ||
                   ((i_lsu_funct3[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
      req_fault  = !legal || misaligned;
      eff_off    = i_lsu_addr[1:0];
    end
`else
    req_fault = !legal;
    // Misaligned halves/words are silently aligned down.
    case (i_lsu_funct3[1:0])
      2'b01:   eff_off = {i_lsu_addr[1], 1'b0};
      2'b10:   eff_off = 2'b00;
      default: eff_off = i_lsu_addr[1:0];
    endcase
`endif
    case (i_lsu_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << eff_off;
        wdata_c = {4{i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {eff_off[1], 1'b0};
        wdata_c = {2{i_lsu_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = i_lsu_wdata;
      end
    endcase
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (i_lsu_valid) state_n = req_fault ? ST_DONE : ST_REQ;
      ST_REQ:  if (i_mem_ack || timeout) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Output / datapath next values; i_mem_ack only matters in REQ.
  always_comb begin
    ready_d  = 1'b0;
    err_d    = o_lsu_err;
    rdata_d  = o_lsu_rdata;
    req_d    = o_mem_req;
    we_d     = o_mem_we;
    addr_d   = o_mem_addr;
    be_d     = o_mem_be;
    wdata_d  = o_mem_wdata;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    wren_d   = wren_q;
    case (state_q)
      ST_IDLE: begin
        if (i_lsu_valid) begin
          if (req_fault) begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            req_d    = 1'b1;
            we_d     = i_lsu_wren;
            addr_d   = i_lsu_addr[31:2];
            be_d     = be_c;
            wdata_d  = wdata_c;
            cnt_d    = '0;
            funct3_d = i_lsu_funct3;
            off_d    = eff_off;
            wren_d   = i_lsu_wren;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = wren_q ? 32'd0 : load_ext(funct3_q, off_q, i_mem_rdata);
        end else if (timeout) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and captured request fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_lsu_ready <= 1'b0;
      o_lsu_err   <= 1'b0;
      o_lsu_rdata <= 32'd0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 30'd0;
      o_mem_be    <= 4'd0;
      o_mem_wdata <= 32'd0;
      cnt_q       <= '0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      wren_q      <= 1'b0;
    end else begin
      o_lsu_ready <= ready_d;
      o_lsu_err   <= err_d;
      o_lsu_rdata <= rdata_d;
      o_mem_req   <= req_d;
      o_mem_we    <= we_d;
      o_mem_addr  <= addr_d;
      o_mem_be    <= be_d;
      o_mem_wdata <= wdata_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      wren_q      <= wren_d;
    end
  end

endmodule
